// File: rtl/mult_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_sched_pkg
// Brief    : Shared state encoding and default sizing for multiplier_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mult_sched_pkg;

    localparam int c_DEFAULT_N       = 32;
    localparam int c_DEFAULT_NREQ    = 4;
    localparam int c_DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BUSY    = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; one-hot grant searching upward
//            from the pointer and wrapping at NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    // NREQ is a power of two, so the IDW-bit sum wraps naturally.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = i_ptr + IDW'(k);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiplier_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_scheduler
// Brief    : Arbitrates NREQ requesters onto one shared sequential multiplier,
//            with a BUSY watchdog and a single registered response channel.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N       = c_DEFAULT_N,
    parameter int NREQ    = c_DEFAULT_NREQ,
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic [N-1:0]            mult_a,
    output logic [N-1:0]            mult_b,
    output logic                    mult_start,
    input  logic                    mult_done,
    input  logic [2*N-1:0]          mult_product,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*N-1:0]          rsp_product,
    output logic                    rsp_error
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    state_t         r_state_q,       w_state_d;
    logic [IDW-1:0] r_ptr_q,         w_ptr_d;
    logic [CW-1:0]  r_wdog_q,        w_wdog_d;
    logic [N-1:0]   r_mult_a_q,      w_mult_a_d;
    logic [N-1:0]   r_mult_b_q,      w_mult_b_d;
    logic [IDW-1:0] r_rsp_id_q,      w_rsp_id_d;
    logic [2*N-1:0] r_rsp_product_q, w_rsp_product_d;
    logic           r_rsp_error_q,   w_rsp_error_d;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr_q),
        .o_grant (w_grant)
    );

    // Grant is one-hot, so at most one slice is selected.
    always_comb begin
        w_grant_idx = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = IDW'(i);
                w_sel_a     = req_a[i*N +: N];
                w_sel_b     = req_b[i*N +: N];
            end
        end
    end

    assign req_ready   = (r_state_q == IDLE && !reset) ? w_grant : '0;
    assign mult_start  = (r_state_q == ISSUE);
    assign rsp_valid   = (r_state_q == RESPOND);
    assign mult_a      = r_mult_a_q;
    assign mult_b      = r_mult_b_q;
    assign rsp_id      = r_rsp_id_q;
    assign rsp_product = r_rsp_product_q;
    assign rsp_error   = r_rsp_error_q;

    always_comb begin
        w_state_d       = r_state_q;
        w_ptr_d         = r_ptr_q;
        w_wdog_d        = r_wdog_q;
        w_mult_a_d      = r_mult_a_q;
        w_mult_b_d      = r_mult_b_q;
        w_rsp_id_d      = r_rsp_id_q;
        w_rsp_product_d = r_rsp_product_q;
        w_rsp_error_d   = r_rsp_error_q;
        case (r_state_q)
            IDLE: begin
                if (|(req_valid & req_ready)) begin
                    w_mult_a_d = w_sel_a;
                    w_mult_b_d = w_sel_b;
                    w_rsp_id_d = w_grant_idx;
                    w_state_d  = ISSUE;
                end
            end
            ISSUE: begin
                w_wdog_d  = '0;
                w_state_d = BUSY;
            end
            BUSY: begin
                // A completion on the expiry cycle still delivers the product.
                if (mult_done) begin
                    w_rsp_product_d = mult_product;
                    w_rsp_error_d   = 1'b0;
                    w_state_d       = RESPOND;
                end else if (r_wdog_q == CW'(TIMEOUT - 1)) begin
                    w_rsp_product_d = '0;
                    w_rsp_error_d   = 1'b1;
                    w_state_d       = RESPOND;
                end else begin
                    w_wdog_d = r_wdog_q + CW'(1);
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    w_ptr_d   = r_rsp_id_q + IDW'(1);
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= IDLE;
            r_ptr_q         <= '0;
            r_wdog_q        <= '0;
            r_mult_a_q      <= '0;
            r_mult_b_q      <= '0;
            r_rsp_id_q      <= '0;
            r_rsp_product_q <= '0;
            r_rsp_error_q   <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_ptr_q         <= w_ptr_d;
            r_wdog_q        <= w_wdog_d;
            r_mult_a_q      <= w_mult_a_d;
            r_mult_b_q      <= w_mult_b_d;
            r_rsp_id_q      <= w_rsp_id_d;
            r_rsp_product_q <= w_rsp_product_d;
            r_rsp_error_q   <= w_rsp_error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_scheduler
// Brief    : Directed self-checking bench with a countdown multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_scheduler;

    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic [N-1:0]      mult_a;
    logic [N-1:0]      mult_b;
    logic              mult_start;
    logic              mult_done;
    logic [2*N-1:0]    mult_product;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [2*N-1:0]    rsp_product;
    logic              rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Multiplier model: done pulses mdl_lat cycles after the start cycle; 0 = never.
    int          mdl_lat = 0;
    int          mdl_cnt = 0;
    logic [N-1:0] cap_a = '0;
    logic [N-1:0] cap_b = '0;
    int          start_cnt = 0;

    always @(posedge clk) begin
        if (mult_start) begin
            mdl_cnt   <= mdl_lat;
            cap_a     <= mult_a;
            cap_b     <= mult_b;
            start_cnt <= start_cnt + 1;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign mult_done    = (mdl_cnt == 1);
    assign mult_product = {32'd0, cap_a} * {32'd0, cap_b};

    always #5 clk = ~clk;

    multiplier_scheduler #(
        .N       (N),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_start   (mult_start),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_product  (rsp_product),
        .rsp_error    (rsp_error)
    );

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_checks++; if (mult_start !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: start=%b valid=%b want 0 0", mult_start, rsp_valid); end
        n_checks++; if (mult_a !== '0 || mult_b !== '0) begin n_fail++; $display("FAIL reset_ops: a=%h b=%h want 0", mult_a, mult_b); end
        n_checks++; if (rsp_product !== '0 || rsp_id !== 2'd0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: prod=%h id=%0d err=%b want 0", rsp_product, rsp_id, rsp_error); end
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_ptr_grant: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single;
        int cyc;
        int s0;
        s0 = start_cnt;
        mdl_lat = 34;
        set_ops(2, 32'd7, 32'd6);
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        n_checks++; if (mult_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", mult_start); end
        n_checks++; if (mult_a !== 32'd7 || mult_b !== 32'd6) begin n_fail++; $display("FAIL single_ops: a=%0d b=%0d want 7 6", mult_a, mult_b); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_issue: got %b want 0000", req_ready); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (mult_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b want 0", mult_start); end
        wait_rsp(cyc);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_timeout: valid=%b want 1", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd2 || rsp_product !== 64'd42 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL single_rsp: id=%0d prod=%0d err=%b want 2 42 0", rsp_id, rsp_product, rsp_error); end
        n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_handshake: valid=%b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin;
        int cyc;
        int e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_lat = 3;
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'd10);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            e = k % NREQ;
            n_checks++; if (req_ready !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << e)); end
            @(negedge clk);
            req_valid[e] = 1'b0;
            wait_rsp(cyc);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_product !== 64'((e + 1) * 10)) begin n_fail++; $display("FAIL rr_rsp[%0d]: valid=%b id=%0d prod=%0d want 1 %0d %0d", k, rsp_valid, rsp_id, rsp_product, e, (e + 1) * 10); end
            @(negedge clk);
            req_valid[e] = 1'b1;
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_max_operands;
        int cyc;
        mdl_lat = 5;
        set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL max_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_product !== 64'hFFFF_FFFE_0000_0001 || rsp_error !== 1'b0 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL max_rsp: valid=%b prod=%h err=%b id=%0d want 1 fffffffe00000001 0 1", rsp_valid, rsp_product, rsp_error, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int cyc;
        mdl_lat = 0;
        set_ops(0, 32'd5, 32'd5);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (mult_start !== 1'b1) begin n_fail++; $display("FAIL timeout_start: got %b want 1", mult_start); end
        wait_rsp(cyc);
        n_checks++; if (cyc !== TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT + 1); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_product !== 64'd0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL timeout_rsp: valid=%b err=%b prod=%h id=%0d want 1 1 0 0", rsp_valid, rsp_error, rsp_product, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL timeout_ptr: got %b want 0010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_done_at_expiry;
        int cyc;
        mdl_lat = TIMEOUT;
        set_ops(3, 32'd3, 32'd5);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        n_checks++; if (cyc !== TIMEOUT + 1) begin n_fail++; $display("FAIL expiry_latency: got %0d want %0d", cyc, TIMEOUT + 1); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_product !== 64'd15 || rsp_id !== 2'd3) begin n_fail++; $display("FAIL expiry_rsp: valid=%b err=%b prod=%0d id=%0d want 1 0 15 3", rsp_valid, rsp_error, rsp_product, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int cyc;
        mdl_lat = 2;
        set_ops(1, 32'd9, 32'd9);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 64'd81 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b id=%0d prod=%0d err=%b want 1 1 81 0", k, rsp_valid, rsp_id, rsp_product, rsp_error); end
            n_checks++; if (req_ready !== 4'b0000 || mult_start !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept[%0d]: ready=%b start=%b want 0000 0", k, req_ready, mult_start); end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid=%b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        bit stray;
        mdl_lat = 20;
        set_ops(2, 32'd4, 32'd4);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mult_a !== '0 || mult_b !== '0 || mult_start !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ops: a=%h b=%h start=%b want 0", mult_a, mult_b, mult_start); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_product !== '0 || rsp_id !== 2'd0 || rsp_error !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_busy_rsp: valid=%b prod=%h id=%0d err=%b ready=%b want 0", rsp_valid, rsp_product, rsp_id, rsp_error, req_ready); end
        reset = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mult_start !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rst_busy_stray_done: activity=%b want 0", stray); end
        req_valid = 4'b1110;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_busy_ptr: got %b want 0010", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_max_operands();
        test_timeout();
        test_done_at_expiry();
        test_backpressure();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "bench time limit expired");
    end

endmodule
`default_nettype wire

// File: doc/multiplier_scheduler.md
MULTIPLIER_SCHEDULER -- requirements
Module: multiplier_scheduler

Interface
REQ-001 Parameter N, default 32: operand width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters; power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 64: maximum BUSY cycles before the watchdog fires.
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid, input, NREQ bits: per-requester request valid.
REQ-007 Port req_ready, output, NREQ bits: per-requester accept, at most one bit high.
REQ-008 Port req_a, input, NREQ*N bits: flattened operand A; requester i uses slice [i*N +: N].
REQ-009 Port req_b, input, NREQ*N bits: flattened operand B, sliced the same way as req_a.
REQ-010 Port mult_a, output, N bits: operand A driven to the shared sequential multiplier.
REQ-011 Port mult_b, output, N bits: operand B driven to the shared sequential multiplier.
REQ-012 Port mult_start, output, 1 bit: one-cycle start pulse to the multiplier.
REQ-013 Port mult_done, input, 1 bit: multiplier completion pulse.
REQ-014 Port mult_product, input, 2N bits: multiplier result, valid when mult_done is high.
REQ-015 Port rsp_valid, output, 1 bit: response valid.
REQ-016 Port rsp_ready, input, 1 bit: response consumer ready.
REQ-017 Port rsp_id, output, clog2(NREQ) bits: index of the requester being answered.
REQ-018 Port rsp_product, output, 2N bits: registered product.
REQ-019 Port rsp_error, output, 1 bit: high when the response is a watchdog timeout; rsp_product is 0 in that case.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, BUSY, RESPOND.
REQ-021 In IDLE, req_ready SHALL be combinational and equal to the one-hot round-robin grant over req_valid, searching from the priority pointer upward and wrapping at NREQ; it SHALL be 0 in all other states.
REQ-022 A request SHALL be accepted on a cycle where req_valid[i] and req_ready[i] are both high; on acceptance the block latches the operands into mult_a/mult_b and the index into rsp_id, and moves to ISSUE.
REQ-023 Requesters SHALL hold req_valid and their operands stable until accepted; the block does not check this.
REQ-024 In ISSUE, mult_start SHALL be high for exactly one cycle, then the FSM moves to BUSY; mult_a and mult_b SHALL stay stable from ISSUE until the FSM leaves BUSY.
REQ-025 In BUSY, a watchdog counter SHALL run from 0 and increment every cycle.
REQ-026 In BUSY, mult_done=1 SHALL latch mult_product into rsp_product, clear rsp_error, and move to RESPOND.
REQ-027 If the counter reaches TIMEOUT-1 without mult_done, the block SHALL set rsp_error=1, set rsp_product=0, and move to RESPOND.
REQ-028 If mult_done arrives on the same cycle as watchdog expiry, mult_done SHALL win.
REQ-029 mult_done SHALL be ignored outside BUSY.
REQ-030 In RESPOND, rsp_valid SHALL be high; rsp_id, rsp_product and rsp_error SHALL be stable until rsp_valid and rsp_ready are both high, after which the FSM returns to IDLE.
REQ-031 On each response handshake, the priority pointer SHALL become (rsp_id+1) mod NREQ.
REQ-032 Minimum accept-to-rsp_valid latency SHALL be 3 cycles plus the multiplier latency; a new accept is possible on the cycle after the response handshake.
REQ-033 The block SHALL have no request queue: only one operation is in flight at a time.

Reset
REQ-034 When reset is high at a clock edge, the FSM SHALL go to IDLE and the priority pointer and watchdog counter SHALL clear to 0.
REQ-035 On the same reset edge, mult_a, mult_b, rsp_product, rsp_id and rsp_error SHALL clear to 0, and mult_start and rsp_valid SHALL go low.
REQ-036 Reset SHALL take effect in any state; an in-flight operation is abandoned with no response, and any later stray mult_done is ignored per REQ-029.
REQ-037 During the reset cycle req_ready SHALL be 0.

Structure
REQ-038 Package mult_sched_pkg SHALL hold the state enum (IDLE, ISSUE, BUSY, RESPOND) and the default constants for N, NREQ and TIMEOUT.
REQ-039 Round-robin grant logic SHALL be a separate combinational sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).
REQ-040 The FSM, operand/result registers, watchdog counter and pointer SHALL live in multiplier_scheduler.

Verification
REQ-041 Single request: requester 2 sends A=7, B=6 with a 34-cycle multiplier model -> one mult_start pulse; rsp_valid with rsp_id=2, rsp_product=42, rsp_error=0.
REQ-042 All four requesters valid, pointer 0 -> grants served in order 0,1,2,3,0; each requester drops valid after its accept and re-raises it.
REQ-043 Max operands: A=B=0xFFFFFFFF -> rsp_product=0xFFFFFFFE00000001.
REQ-044 Multiplier model never asserts done -> rsp_error=1 and rsp_product=0 after TIMEOUT BUSY cycles; pointer advances.
REQ-045 Backpressure and reset: rsp_ready held low for 10 cycles -> response fields stable and no new accept. Separately, reset asserted mid-BUSY -> IDLE with all outputs 0, and a later mult_done produces no response.
